// File: rtl/freq_counter_pkg.sv
// Shared definitions for the frequency counter: ASCII codes and the
// 3-bit state encoding used by the count reporter FSM.
package freq_counter_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONVERT   = 3'd1,
        ST_LOAD      = 3'd2,
        ST_STROBE    = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_NEXT      = 3'd5
    } rep_state_e;

endpackage

// File: rtl/uart_count_reporter_bin2bcd.sv
// Sequential double-dabble: one binary bit per cycle, COUNT_WIDTH cycles after
// start, then a one-cycle done pulse with the BCD result held on bcd.
module bin2bcd_seq #(
    parameter int COUNT_WIDTH = 32,
    parameter int NUM_DIGITS  = 10
) (
    input  logic                      i_Clock,
    input  logic                      i_Rst_L,
    input  logic                      start,
    input  logic [COUNT_WIDTH-1:0]    bin,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd
);
    localparam int CNT_W = $clog2(COUNT_WIDTH + 1);

    logic [COUNT_WIDTH-1:0]  shift_q, shift_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;

    // Digits only ever hold 0..9 here, so +3 on 5..9 stays within 4 bits.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (start) begin
            shift_d = bin;
            bcd_d   = '0;
            cnt_d   = CNT_W'(COUNT_WIDTH);
        end else if (cnt_q != '0) begin
            bcd_d   = {bcd_adj[4*NUM_DIGITS-2:0], shift_q[COUNT_WIDTH-1]};
            shift_d = {shift_q[COUNT_WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - 1'b1;
            done_d  = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/uart_count_reporter.sv
// Converts a binary count to decimal ASCII and streams it, followed by CR LF,
// into the UART TX byte handshake. Counts arriving mid-report are dropped.
module uart_count_reporter
    import freq_counter_pkg::*;
#(
    parameter int COUNT_WIDTH    = 32,
    parameter int NUM_DIGITS     = 10,
    parameter int SUPPRESS_ZEROS = 1
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_L,
    input  logic                   i_Count_DV,
    input  logic [COUNT_WIDTH-1:0] i_Count,
    output logic                   o_Busy,
    output logic                   o_Drop,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done
);
    localparam int IDX_W = $clog2(NUM_DIGITS + 2);
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] CR_IDX     = IDX_W'(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LF_IDX     = IDX_W'(NUM_DIGITS + 1);

    rep_state_e              state_q, state_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    seen_q, seen_d;
    logic [7:0]              byte_q, byte_d;

    logic                    conv_start, conv_done, skip;
    logic [4*NUM_DIGITS-1:0] conv_bcd;
    logic [3:0]              cur_digit;

    assign conv_start = (state_q == ST_IDLE) && i_Count_DV;

    bin2bcd_seq #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_bin2bcd (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .start   (conv_start),
        .bin     (i_Count),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    // digits_q is consumed most-significant nibble first by shifting left.
    assign cur_digit = digits_q[4*NUM_DIGITS-1 -: 4];
    assign skip = (SUPPRESS_ZEROS != 0) && (state_q == ST_LOAD) &&
                  (idx_q < LAST_DIGIT) && (cur_digit == 4'd0) && !seen_q;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (i_Count_DV) state_d = ST_CONVERT;
            ST_CONVERT:   if (conv_done) state_d = ST_LOAD;
            ST_LOAD:      if (!skip) state_d = ST_STROBE;
            ST_STROBE:    if (!i_TX_Active) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (i_TX_Done) state_d = (idx_q == LF_IDX) ? ST_IDLE : ST_NEXT;
            ST_NEXT:      state_d = ST_LOAD;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        idx_d    = idx_q;
        seen_d   = seen_q;
        byte_d   = byte_q;
        case (state_q)
            ST_CONVERT: if (conv_done) begin
                digits_d = conv_bcd;
                idx_d    = '0;
                seen_d   = 1'b0;
            end
            ST_LOAD: if (skip) begin
                digits_d = digits_q << 4;
                idx_d    = idx_q + 1'b1;
            end else begin
                seen_d = 1'b1;
                if (idx_q < CR_IDX)       byte_d = ASCII_ZERO + {4'h0, cur_digit};
                else if (idx_q == CR_IDX) byte_d = ASCII_CR;
                else                      byte_d = ASCII_LF;
            end
            ST_NEXT: begin
                if (idx_q < CR_IDX) digits_d = digits_q << 4;
                idx_d = idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            digits_q <= '0;
            idx_q    <= '0;
            seen_q   <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            digits_q <= digits_d;
            idx_q    <= idx_d;
            seen_q   <= seen_d;
            byte_q   <= byte_d;
        end
    end

    always_comb begin
        o_Busy    = (state_q != ST_IDLE);
        o_Drop    = (state_q != ST_IDLE) && i_Count_DV;
        o_TX_DV   = (state_q == ST_STROBE) && !i_TX_Active;
        o_TX_Byte = byte_q;
    end

endmodule

// File: tb/tb_uart_count_reporter.sv
// Directed bench: two reporters (zero suppression on/off) driving simple UART TX models.
module tb_uart_count_reporter;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    logic          cdv_s = 1'b0, cdv_z = 1'b0;
    logic [CW-1:0] cnt_s = '0, cnt_z = '0;
    logic          busy_s, drop_s, dv_s, busy_z, drop_z, dv_z;
    logic [7:0]    byte_s, byte_z;
    logic          act_s = 1'b0, done_s = 1'b0, act_z = 1'b0, done_z = 1'b0;
    int            tmr_s = 0, tmr_z = 0;

    uart_count_reporter #(.COUNT_WIDTH(CW), .NUM_DIGITS(10), .SUPPRESS_ZEROS(1)) dut_s (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_Count_DV(cdv_s), .i_Count(cnt_s),
        .o_Busy(busy_s), .o_Drop(drop_s), .o_TX_DV(dv_s), .o_TX_Byte(byte_s),
        .i_TX_Active(act_s), .i_TX_Done(done_s));

    uart_count_reporter #(.COUNT_WIDTH(CW), .NUM_DIGITS(10), .SUPPRESS_ZEROS(0)) dut_z (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_Count_DV(cdv_z), .i_Count(cnt_z),
        .o_Busy(busy_z), .o_Drop(drop_z), .o_TX_DV(dv_z), .o_TX_Byte(byte_z),
        .i_TX_Active(act_z), .i_TX_Done(done_z));

    // Behavioural UART TX: busy for 20 cycles after a strobe, then a Done pulse.
    always @(posedge clk) begin
        done_s <= 1'b0;
        if (dv_s) begin
            act_s <= 1'b1; tmr_s <= 20;
        end else if (tmr_s != 0) begin
            tmr_s <= tmr_s - 1;
            if (tmr_s == 1) begin done_s <= 1'b1; act_s <= 1'b0; end
        end
    end
    always @(posedge clk) begin
        done_z <= 1'b0;
        if (dv_z) begin
            act_z <= 1'b1; tmr_z <= 20;
        end else if (tmr_z != 0) begin
            tmr_z <= tmr_z - 1;
            if (tmr_z == 1) begin done_z <= 1'b1; act_z <= 1'b0; end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] cap_s[$], cap_z[$];
    logic prev_s = 1'b0, prev_z = 1'b0;
    int viol = 0, first_dv = -1;

    always @(negedge clk) begin
        if (rst_l) begin
            if (dv_s) begin
                cap_s.push_back(byte_s);
                if (act_s || prev_s) viol <= viol + 1;
                if (first_dv < 0) first_dv <= cyc;
            end
            if (dv_z) begin
                cap_z.push_back(byte_z);
                if (act_z || prev_z) viol <= viol + 1;
            end
        end
        prev_s <= dv_s;
        prev_z <= dv_z;
    end

    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Pulse a count into one reporter; returns the cycle stamp of the strobe.
    task automatic send(input bit zinst, input logic [CW-1:0] v, output int t0);
        @(negedge clk);
        t0 = cyc;
        if (zinst) begin cdv_z = 1'b1; cnt_z = v; end
        else       begin cdv_s = 1'b1; cnt_s = v; end
        @(negedge clk);
        cdv_s = 1'b0; cdv_z = 1'b0;
    endtask

    task automatic wait_idle(input bit zinst, input string tag);
        int n = 0;
        while ((zinst ? busy_z : busy_s) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(n >= 3000), 64'd0);
    endtask

    task automatic check_bytes(input bit zinst, input string tag, input string digits);
        logic [7:0] exp[$];
        int ncap;
        for (int i = 0; i < digits.len(); i++) exp.push_back(digits[i]);
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
        ncap = zinst ? cap_z.size() : cap_s.size();
        check({tag, "_len"}, 64'(ncap), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < ncap; i++)
            check($sformatf("%s_b%0d", tag, i), 64'(zinst ? cap_z[i] : cap_s[i]), 64'(exp[i]));
    endtask

    initial begin
        int t0, n;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_s), 64'd0);
        check("rst_txdv", 64'(dv_s), 64'd0);
        check("rst_byte", 64'(byte_s), 64'h00);
        check("rst_drop", 64'(drop_s), 64'd0);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);

        // Count 0: a single '0' digit; also first-byte latency bound.
        first_dv = -1;
        send(1'b0, 32'd0, t0);
        wait_idle(1'b0, "zero");
        check_bytes(1'b0, "zero", "0");
        check("zero_latency_ok", 64'((first_dv - t0) >= CW + 2), 64'd1);
        check("zero_busy_after", 64'(busy_s), 64'd0);
        cap_s.delete();

        send(1'b0, 32'd1234, t0);
        wait_idle(1'b0, "c1234");
        check_bytes(1'b0, "c1234", "1234");
        cap_s.delete();

        send(1'b0, 32'hFFFF_FFFF, t0);
        wait_idle(1'b0, "cmax");
        check_bytes(1'b0, "cmax", "4294967295");
        cap_s.delete();

        send(1'b1, 32'd42, t0);
        wait_idle(1'b1, "nosup42");
        check_bytes(1'b1, "nosup42", "0000000042");
        cap_z.delete();

        // Count arriving mid-report is dropped with a one-cycle flag.
        send(1'b0, 32'd77, t0);
        repeat (50) @(negedge clk);
        cdv_s = 1'b1; cnt_s = 32'd5;
        #1;
        check("drop_pulse", 64'(drop_s), 64'd1);
        @(negedge clk);
        cdv_s = 1'b0;
        #1;
        check("drop_cleared", 64'(drop_s), 64'd0);
        wait_idle(1'b0, "c77");
        repeat (60) @(negedge clk);
        check("c77_no_second", 64'(busy_s), 64'd0);
        check_bytes(1'b0, "c77", "77");
        cap_s.delete();

        // Reset while waiting for Done of the second digit.
        send(1'b0, 32'd9876, t0);
        n = 0;
        while (cap_s.size() < 2 && n < 3000) begin @(negedge clk); n++; end
        check("rst_reach_2nd", 64'(cap_s.size()), 64'd2);
        repeat (5) @(negedge clk);
        rst_l = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_s), 64'd0);
        check("midrst_txdv", 64'(dv_s), 64'd0);
        check("midrst_byte", 64'(byte_s), 64'h00);
        check("midrst_drop", 64'(drop_s), 64'd0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        cap_s.delete();
        repeat (40) @(negedge clk);
        check("postrst_no_bytes", 64'(cap_s.size()), 64'd0);
        send(1'b0, 32'd9, t0);
        wait_idle(1'b0, "c9");
        check_bytes(1'b0, "c9", "9");

        check("dv_protocol_viol", 64'(viol), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
